// File: rtl/ariane_ace_pkg.sv
// Shared ACE definitions for the snoop initiator: CRRESP bit positions, ACSNOOP codes, command/response structs, FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ariane_ace_pkg;

  // CRRESP bit positions
  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  // ACSNOOP encodings
  localparam logic [3:0] AcReadOnce           = 4'b0000;
  localparam logic [3:0] AcReadShared         = 4'b0001;
  localparam logic [3:0] AcReadClean          = 4'b0010;
  localparam logic [3:0] AcReadNotSharedDirty = 4'b0011;
  localparam logic [3:0] AcReadUnique         = 4'b0111;
  localparam logic [3:0] AcCleanShared        = 4'b1000;
  localparam logic [3:0] AcCleanInvalid       = 4'b1001;
  localparam logic [3:0] AcMakeInvalid        = 4'b1101;

  typedef enum logic [2:0] {
    SNP_IDLE,
    SNP_SEND_AC,
    SNP_WAIT_CR,
    SNP_RECV_CD,
    SNP_RESP
  } snp_state_e;

  // Registered AC command fields (address kept separately, its width is a parameter)
  typedef struct packed {
    logic [3:0] snoop;
    logic [2:0] prot;
  } ac_cmd_t;

  // CRRESP laid out MSB first so the struct packs to the bus encoding
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  // Number of byte-offset address bits inside one cache line
  function automatic int unsigned line_offset_bits(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/ace_cd_collector.sv
// CD beat collector: counts beats, assembles the line, flags misplaced/missing CDLAST.
// Latency: one beat stored per handshake cycle; line visible the cycle after the final beat.
// Backpressure: cd_ready_o only while enabled and fewer than a full line of beats is held.
module ace_cd_collector #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineWidth = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic                 cd_valid_i,
  input  logic [DataWidth-1:0] cd_data_i,
  input  logic                 cd_last_i,
  output logic                 cd_ready_o,
  output logic                 cd_hs_o,
  output logic                 full_next_o,
  output logic                 empty_o,
  output logic [LineWidth-1:0] line_o,
  output logic                 err_o
);

  localparam int unsigned Beats    = LineWidth / DataWidth;
  localparam int unsigned CntWidth = $clog2(Beats + 1);

  logic [CntWidth-1:0]  cnt_q;
  logic [LineWidth-1:0] line_q;
  logic                 err_q;
  logic                 final_beat;

  assign cd_ready_o  = en_i && (cnt_q < CntWidth'(Beats));
  assign cd_hs_o     = cd_valid_i && cd_ready_o;
  assign final_beat  = (cnt_q == CntWidth'(Beats - 1));
  // Counting the beat in flight lets the FSM finish on the same cycle the line completes
  assign full_next_o = ((cnt_q + CntWidth'(cd_hs_o)) == CntWidth'(Beats));
  assign empty_o     = (cnt_q == '0);
  assign line_o      = line_q;
  assign err_o       = err_q;

  // Store each accepted beat at its slot and check CDLAST against the beat position
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q  <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else if (cd_hs_o) begin
      cnt_q <= cnt_q + CntWidth'(1);
      for (int k = 0; k < Beats; k++) begin
        if (cnt_q == CntWidth'(k)) begin
          line_q[k*DataWidth +: DataWidth] <= cd_data_i;
        end
      end
      if (cd_last_i != final_beat) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ace_snoop_initiator.sv
// ACE snoop master: issues one snoop on AC, gathers CR and the CD line, returns both to the requester.
// Latency: accept -> rsp_valid_o 3 cycles with immediate AC/CR handshakes and no data.
// Backpressure: AC fields and rsp_* held until ready; one snoop outstanding. Watchdog via ACE_SNOOP_TIMEOUT_EN.
module ace_snoop_initiator
  import ariane_ace_pkg::*;
#(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned LineWidth     = 128,
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [3:0]           req_snoop_i,
  input  logic [2:0]           req_prot_i,
  output logic                 ac_valid_o,
  input  logic                 ac_ready_i,
  output logic [AddrWidth-1:0] ac_addr_o,
  output logic [3:0]           ac_snoop_o,
  output logic [2:0]           ac_prot_o,
  input  logic                 cr_valid_i,
  output logic                 cr_ready_o,
  input  logic [4:0]           cr_resp_i,
  input  logic                 cd_valid_i,
  output logic                 cd_ready_o,
  input  logic [DataWidth-1:0] cd_data_i,
  input  logic                 cd_last_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [4:0]           rsp_cr_o,
  output logic [LineWidth-1:0] rsp_data_o,
  output logic                 rsp_err_o
);

  localparam int unsigned          OffBits  = line_offset_bits(LineWidth);
  localparam logic [AddrWidth-1:0] AddrMask = ~((AddrWidth'(1) << OffBits) - AddrWidth'(1));

  snp_state_e           state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  ac_cmd_t              cmd_q;
  crresp_t              cr_q;
  logic                 err_q;

  logic cmd_accept;
  logic cr_hs;
  logic cd_en;
  logic cd_hs;
  logic cd_full_next;
  logic cd_empty;
  logic cd_err;
  logic waiting;
  logic tmo_hit;
  logic tmo_fire;

  assign cmd_accept = (state_q == SNP_IDLE) && req_valid_i;
  assign cr_hs      = cr_valid_i && cr_ready_o;
  assign waiting    = (state_q == SNP_WAIT_CR) || (state_q == SNP_RECV_CD);

  ace_cd_collector #(
    .DataWidth (DataWidth),
    .LineWidth (LineWidth)
  ) u_cd_collector (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (cmd_accept),
    .en_i        (cd_en),
    .cd_valid_i  (cd_valid_i),
    .cd_data_i   (cd_data_i),
    .cd_last_i   (cd_last_i),
    .cd_ready_o  (cd_ready_o),
    .cd_hs_o     (cd_hs),
    .full_next_o (cd_full_next),
    .empty_o     (cd_empty),
    .line_o      (rsp_data_o),
    .err_o       (cd_err)
  );

`ifdef ACE_SNOOP_TIMEOUT_EN
  logic [31:0] tmo_q;

  // Watchdog: restarts with each new command, runs only while waiting on CR/CD
  always_ff @(posedge clk_i) begin
    if (rst_i || cmd_accept) begin
      tmo_q <= '0;
    end else if (waiting) begin
      tmo_q <= tmo_q + 32'd1;
    end
  end

  assign tmo_hit = waiting && (tmo_q == TimeoutCycles);
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SNP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; real handshakes take priority over the watchdog
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    unique case (state_q)
      SNP_IDLE: begin
        if (req_valid_i) state_d = SNP_SEND_AC;
      end
      SNP_SEND_AC: begin
        if (ac_ready_i) state_d = SNP_WAIT_CR;
      end
      SNP_WAIT_CR: begin
        if (cr_valid_i) begin
          if (cr_resp_i[CrDataTransfer] && !cd_full_next) state_d = SNP_RECV_CD;
          else                                            state_d = SNP_RESP;
        end else if (tmo_hit) begin
          state_d  = SNP_RESP;
          tmo_fire = 1'b1;
        end
      end
      SNP_RECV_CD: begin
        if (cd_hs && cd_full_next) begin
          state_d = SNP_RESP;
        end else if (tmo_hit) begin
          state_d  = SNP_RESP;
          tmo_fire = 1'b1;
        end
      end
      SNP_RESP: begin
        if (rsp_ready_i) state_d = SNP_IDLE;
      end
      default: state_d = SNP_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; forced low while reset is asserted
  always_comb begin
    req_ready_o = 1'b0;
    ac_valid_o  = 1'b0;
    cr_ready_o  = 1'b0;
    cd_en       = 1'b0;
    rsp_valid_o = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        SNP_IDLE:    req_ready_o = 1'b1;
        SNP_SEND_AC: ac_valid_o  = 1'b1;
        SNP_WAIT_CR: begin
          cr_ready_o = 1'b1;
          cd_en      = 1'b1;
        end
        SNP_RECV_CD: cd_en       = 1'b1;
        SNP_RESP:    rsp_valid_o = 1'b1;
        default: ;
      endcase
    end
  end

  // Command, CR capture and transaction-level error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      cmd_q  <= '0;
      cr_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (cmd_accept) begin
        addr_q <= req_addr_i & AddrMask;
        cmd_q  <= '{snoop: req_snoop_i, prot: req_prot_i};
        cr_q   <= '0;
        err_q  <= 1'b0;
      end
      if (cr_hs) begin
        cr_q <= crresp_t'(cr_resp_i);
        // CD beats for a response that claims no data transfer
        if (!cr_resp_i[CrDataTransfer] && (!cd_empty || cd_hs)) begin
          err_q <= 1'b1;
        end
      end
      if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ac_addr_o  = addr_q;
  assign ac_snoop_o = cmd_q.snoop;
  assign ac_prot_o  = cmd_q.prot;
  assign rsp_cr_o   = cr_q;
  assign rsp_err_o  = err_q | cd_err | cr_q.error;

endmodule
